// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a 32-bit word as four 8N1 UART frames,
// then acknowledges the requester with a four-phase send/send_done handshake.
module uart_word_tx #(
    parameter int CLKS_PER_BIT   = 5208,
    parameter bit MSB_BYTE_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [31:0] data,
    output logic        send_done,
    output logic        busy,
    output logic        tx,
    output logic [2:0]  state_dbg
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [1:0]    byte_idx, byte_idx_n;
    logic [31:0]   word, word_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n, busy_n, done_n;
    logic [1:0]    sel;
    logic [7:0]    cur_byte;
    logic          bit_end;

    // For MSB-first order, byte k maps to lane 3-k, i.e. the inverted index.
    assign sel      = MSB_BYTE_FIRST ? ~byte_idx : byte_idx;
    assign cur_byte = word[{sel, 3'b000} +: 8];
    assign bit_end  = (baud == BAUD_MAX);

    always_comb begin
        state_n    = state;
        baud_n     = bit_end ? '0 : baud + 1'b1;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        word_n     = word;
        shreg_n    = shreg;
        tx_n       = tx;
        busy_n     = busy;
        done_n     = send_done;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (send) begin
                    state_n    = START;
                    word_n     = data;
                    byte_idx_n = 2'd0;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    // shreg holds the bits still pending after the one on tx
                    shreg_n   = {1'b0, cur_byte[7:1]};
                    bit_idx_n = 3'd0;
                    tx_n      = cur_byte[0];
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shreg_n   = {1'b0, shreg[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shreg[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx != 2'd3) begin
                        byte_idx_n = byte_idx + 2'd1;
                        state_n    = START;
                        tx_n       = 1'b0;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        tx_n    = 1'b1;
                    end
                end
            end
            DONE: begin
                baud_n = '0;
                if (!send) begin
                    done_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            word      <= 32'd0;
            shreg     <= 8'd0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            send_done <= 1'b0;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            word      <= word_n;
            shreg     <= shreg_n;
            tx        <= tx_n;
            busy      <= busy_n;
            send_done <= done_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed bench, LSB-first (dut0) and MSB-first (dut1)
// instances driven in parallel with CLKS_PER_BIT=4.
module tb_uart_word_tx;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [31:0] data;
    logic        done0, busy0, tx0;
    logic        done1, busy1, tx1;
    logic [2:0]  st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_word_tx #(.CLKS_PER_BIT(NB), .MSB_BYTE_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .send_done(done0), .busy(busy0), .tx(tx0), .state_dbg(st0)
    );

    uart_word_tx #(.CLKS_PER_BIT(NB), .MSB_BYTE_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .send_done(done1), .busy(busy1), .tx(tx1), .state_dbg(st1)
    );

    // Bytes in order of appearance, first byte in the top lane.
    function automatic logic [31:0] word_of(input logic [39:0] f);
        logic [31:0] s = 32'd0;
        for (int k = 0; k < 4; k++) s = {s[23:0], f[10*k+1 +: 8]};
        return s;
    endfunction

    function automatic logic frame_ok(input logic [39:0] f);
        logic ok = 1'b1;
        for (int k = 0; k < 4; k++)
            if (f[10*k] !== 1'b0 || f[10*k+9] !== 1'b1) ok = 1'b0;
        return ok;
    endfunction

    // Starts a word and samples each bit near its start; j counts
    // negedges after the accept edge. sd holds send_done at j=159..161.
    task automatic xfer(input logic [31:0] d, input int drop_j,
                        output logic [39:0] f0, output logic [39:0] f1,
                        output logic found, output logic bmid,
                        output logic [2:0] sd);
        data = d;
        send = 1'b1;
        f0 = '0;
        f1 = '0;
        sd = '0;
        bmid = 1'b0;
        @(negedge clk);
        found = (tx0 === 1'b0) && (tx1 === 1'b0);
        for (int j = 1; j <= 161; j++) begin
            @(negedge clk);
            if (j % NB == 1 && j / NB < 40) begin
                f0[j/NB] = tx0;
                f1[j/NB] = tx1;
            end
            if (j == 80) bmid = busy0;
            if (j >= 159) sd[j-159] = done0;
            if (j == drop_j) begin
                send = 1'b0;
                data = 32'hFFFF_FFFF;
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        send = 1'b0;
        data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx0 !== 1'b1 || tx1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx got %b/%b want 1/1", tx0, tx1);
        end
        n_checks++;
        if (done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b want 0", done0);
        end
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", busy0);
        end
        n_checks++;
        if (st0 !== 3'd0 || st1 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state got %0d/%0d want 0", st0, st1);
        end
        repeat (20) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || tx1 !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_idle_tx got %0d low cycles want 0", bad);
        end
    endtask

    task automatic test_basic();
        logic [39:0] f0, f1;
        logic found, bmid;
        logic [2:0] sd;
        xfer(32'hA53C_0F81, 0, f0, f1, found, bmid, sd);
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start got tx=%b want 0", tx0);
        end
        n_checks++;
        if (frame_ok(f0) !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_framing got %h want start0/stop1", f0);
        end
        n_checks++;
        if (word_of(f0) !== 32'h810F_3CA5) begin
            n_fail++;
            $display("FAIL basic_bytes got %h want 810f3ca5", word_of(f0));
        end
        n_checks++;
        if (bmid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy got %b want 1", bmid);
        end
        n_checks++;
        if (sd !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_done_timing got %b want 110", sd);
        end
        n_checks++;
        if (busy0 !== 1'b0 || st0 !== 3'd4) begin
            n_fail++;
            $display("FAIL basic_done_state got busy=%b st=%0d want 0/4",
                     busy0, st0);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done0 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done_hold got %b want 1", done0);
        end
        send = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b0 || st0 !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_done_fall got done=%b st=%0d want 0/0",
                     done0, st0);
        end
    endtask

    task automatic test_byte_order();
        logic [39:0] f0, f1;
        logic found, bmid;
        logic [2:0] sd;
        xfer(32'hA53C_0F81, 0, f0, f1, found, bmid, sd);
        n_checks++;
        if (frame_ok(f1) !== 1'b1) begin
            n_fail++;
            $display("FAIL order_framing got %h want start0/stop1", f1);
        end
        n_checks++;
        if (word_of(f1) !== 32'hA53C_0F81) begin
            n_fail++;
            $display("FAIL order_bytes got %h want a53c0f81", word_of(f1));
        end
        n_checks++;
        if (done1 !== 1'b1) begin
            n_fail++;
            $display("FAIL order_done got %b want 1", done1);
        end
        send = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held();
        logic [39:0] f0, f1;
        logic found, bmid;
        logic [2:0] sd;
        int bad = 0;
        xfer(32'h0123_4567, 0, f0, f1, found, bmid, sd);
        n_checks++;
        if (word_of(f0) !== 32'h6745_2301) begin
            n_fail++;
            $display("FAIL held_bytes got %h want 67452301", word_of(f0));
        end
        repeat (500) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || done0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL held_one_word got %0d bad cycles want 0", bad);
        end
        send = 1'b0;
        repeat (2) @(negedge clk);
        xfer(32'hDEAD_BEEF, 0, f0, f1, found, bmid, sd);
        n_checks++;
        if (found !== 1'b1 || word_of(f0) !== 32'hEFBE_ADDE) begin
            n_fail++;
            $display("FAIL held_second got start=%b bytes=%h want 1/efbeadde",
                     found, word_of(f0));
        end
        send = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_change();
        logic [39:0] f0, f1;
        logic found, bmid;
        logic [2:0] sd;
        xfer(32'h1234_5678, 45, f0, f1, found, bmid, sd);
        n_checks++;
        if (frame_ok(f0) !== 1'b1 || word_of(f0) !== 32'h7856_3412) begin
            n_fail++;
            $display("FAIL mid_bytes got %h want 78563412", word_of(f0));
        end
        n_checks++;
        if (sd !== 3'b010) begin
            n_fail++;
            $display("FAIL mid_done_pulse got %b want 010", sd);
        end
        n_checks++;
        if (st0 !== 3'd0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_idle got st=%0d busy=%b want 0/0", st0, busy0);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        data = 32'hCAFE_F00D;
        send = 1'b1;
        @(negedge clk);
        repeat (92) @(negedge clk);
        n_checks++;
        if (st0 !== 3'd2 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_phase got st=%0d busy=%b want 2/1", st0, busy0);
        end
        rst = 1'b1;
        send = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || st0 !== 3'd0)
        begin
            n_fail++;
            $display("FAIL rmid_reset got tx=%b busy=%b done=%b st=%0d want 1/0/0/0",
                     tx0, busy0, done0, st0);
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || st0 !== 3'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rmid_quiet got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        send = 1'b0;
        data = 32'd0;
        test_reset();
        test_basic();
        test_byte_order();
        test_held();
        test_mid_change();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
